miner_host_master: RTL and testbench
====================================

MINER_HOST_MASTER -- requirements
Module: miner_host_master

Interface
REQ-001 SHALL have parameter POLL_GAP, default 4, idle cycles between status polls (min 1).
REQ-002 SHALL have parameter STATUS_ADDR, default 0, read address of status word: bit0 complete, bit1 found.
REQ-003 SHALL have parameter NONCE_ADDR, default 10, read address of found-nonce word.
REQ-004 SHALL have ports clk (input, 1, sole clock) and n_rst (input, 1); reset is synchronous and active-low.
REQ-005 SHALL have job_valid (input, 1), job_ready (output, 1), job_target (input, 256), job_msg (input, 608): upstream job handshake.
REQ-006 SHALL have res_valid (output, 1), res_ready (input, 1), res_found (output, 1), res_nonce (output, 32): result handshake.
REQ-007 SHALL have abort (input, 1): cancels the current job.
REQ-008 SHALL have master_addr (output, 5), master_writedata (output, 32), master_write (output, 1), master_read (output, 1), master_chipselect (output, 1), master_readdata (input, 32).

Function
REQ-009 FSM states SHALL be IDLE, WR_TGT, WR_MSG, CTRL_CLR, CTRL_SET, POLL_WAIT, POLL_RD, NONCE_RD, RESULT.
REQ-010 IDLE: job_ready=1; on job_valid&job_ready SHALL capture target/msg and go to WR_TGT next cycle.
REQ-011 Each bus access SHALL be one cycle with chipselect=1 and exactly one of write/read=1; no waitrequest.
REQ-012 WR_TGT SHALL issue 8 back-to-back writes: word i (0..7) = target[32i+31:32i] to address 2+i.
REQ-013 WR_MSG SHALL issue 19 back-to-back writes: word j (0..18) = msg[32j+31:32j] to address 11+j.
REQ-014 CTRL_CLR SHALL write 0 to address 1; CTRL_SET SHALL then write 3 to address 1 (rising edges on newTarget and newMsg).
REQ-015 POLL_WAIT SHALL idle the bus POLL_GAP cycles, then POLL_RD issues one read of STATUS_ADDR.
REQ-016 Read data SHALL be sampled exactly one cycle after the read strobe (fixed read latency 1).
REQ-017 Status complete=0 SHALL return to POLL_WAIT; complete=1,found=1 SHALL go to NONCE_RD; complete=1,found=0 SHALL go to RESULT with res_nonce=0.
REQ-018 NONCE_RD SHALL read NONCE_ADDR and latch its data into res_nonce, then go to RESULT.
REQ-019 RESULT SHALL hold res_valid=1 and stable res_found/res_nonce until res_ready=1; then return to IDLE.
REQ-020 job_ready SHALL be 0 in every state except IDLE; jobs offered while busy are not accepted.
REQ-021 Job start to first status read SHALL be exactly 29+POLL_GAP cycles after the accepting cycle (8+19+2 writes, POLL_GAP idle).
REQ-022 abort=1 in any non-IDLE state SHALL drop all bus strobes that cycle and enter CTRL_CLR-abort path: one write of 0 to address 1, then IDLE, with no res_valid.
REQ-023 abort in IDLE SHALL be ignored; abort and res_ready together in RESULT SHALL complete the handshake normally.
REQ-024 Word and poll-gap counters SHALL wrap to 0 on state entry; no counter value beyond its range SHALL reach the bus.
REQ-025 Bus outputs SHALL be registered; master_writedata/addr SHALL be 0 when no strobe is active.

Reset
REQ-026 On n_rst=0 at a clk edge: state IDLE, job_ready=1, res_valid=0, res_found=0, res_nonce=0, all master outputs 0, counters 0, captured job cleared.
REQ-027 Reset mid-job SHALL abandon the job with no control-register write.

Structure
REQ-028 Register addresses (CTRL=1, TGT_BASE=2, MSG_BASE=11), word counts (8, 19) and the FSM state enum SHALL live in shared package miner_pkg.
REQ-029 Poll-gap timer SHALL be an instance of the existing counter module; no other sub-module.

Verification
REQ-030 Job target=256'h1, msg word j=j, slave model complete on 3rd poll, found=1, nonce=32'h0000_BEEF -> 29 writes in order, res_valid with res_found=1, res_nonce=32'h0000_BEEF.
REQ-031 Slave returns complete=1, found=0 on 1st poll -> no NONCE_ADDR read, res_found=0, res_nonce=0.
REQ-032 POLL_GAP=4, first status read at cycle 33 after acceptance; subsequent reads spaced 6 cycles (4 gap + read + data).
REQ-033 abort asserted during WR_MSG word 5 -> next cycle single write 0 to address 1, then job_ready=1, res_valid never asserted.
REQ-034 res_ready held 0 for 10 cycles in RESULT -> outputs stable, job_valid ignored, accepted only after res_ready pulse.
REQ-035 n_rst=0 during POLL_WAIT -> next edge all outputs at reset values, no bus strobe.

Source files
------------

// File: rtl/miner_pkg.sv
// Shared definitions for the miner host master: register map, word counts,
// FSM state encoding and bus-word helpers.
package miner_pkg;

   // Register map of the miner slave
   localparam logic [4:0]  CTRL_ADDR    = 5'd1;
   localparam logic [4:0]  TGT_BASE     = 5'd2;
   localparam logic [4:0]  MSG_BASE     = 5'd11;

   // Job geometry in 32-bit words
   localparam int          TGT_WORDS    = 8;
   localparam int          MSG_WORDS    = 19;
   localparam logic [4:0]  TGT_LAST     = 5'd7;
   localparam logic [4:0]  MSG_LAST     = 5'd18;

   // Control register values: clear, then raise newTarget and newMsg together
   localparam logic [31:0] CTRL_CLR_VAL = 32'd0;
   localparam logic [31:0] CTRL_SET_VAL = 32'd3;

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      WR_TGT    = 4'd1,
      WR_MSG    = 4'd2,
      CTRL_CLR  = 4'd3,
      CTRL_SET  = 4'd4,
      POLL_WAIT = 4'd5,
      POLL_RD   = 4'd6,
      NONCE_RD  = 4'd7,
      RESULT    = 4'd8
   } state_e;

   // One cycle of master bus activity
   typedef struct packed {
      logic        cs;
      logic        wr;
      logic        rd;
      logic [4:0]  addr;
      logic [31:0] wdata;
   } bus_t;

   function automatic bus_t bus_write(input logic [4:0] addr, input logic [31:0] data);
      bus_t b;
      b.cs    = 1'b1;
      b.wr    = 1'b1;
      b.rd    = 1'b0;
      b.addr  = addr;
      b.wdata = data;
      return b;
   endfunction

   function automatic bus_t bus_read(input logic [4:0] addr);
      bus_t b;
      b.cs    = 1'b1;
      b.wr    = 1'b0;
      b.rd    = 1'b1;
      b.addr  = addr;
      b.wdata = 32'd0;
      return b;
   endfunction

endpackage

// File: rtl/miner_host_master_counter.sv
// Free-running up-counter with synchronous clear; used as the poll-gap timer.
module miner_host_master_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             clr,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // Clear has priority over increment
   always_comb begin
      if (clr) begin
         count_d = '0;
      end else if (en) begin
         count_d = count_q + WIDTH'(1);
      end else begin
         count_d = count_q;
      end
   end

   // Count register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/miner_host_master.sv
// Host-side bus master for the miner core: loads a job (target + message)
// into the slave's register file, kicks the control register, polls the
// status word and returns found/nonce over a valid/ready handshake.
// Bus outputs are registered and are derived from the next state, so the
// registered state always names the access currently on the bus.
module miner_host_master
   import miner_pkg::*;
#(
   parameter int         POLL_GAP    = 4,
   parameter logic [4:0] STATUS_ADDR = 5'd0,
   parameter logic [4:0] NONCE_ADDR  = 5'd10
) (
   input  logic         clk,
   input  logic         n_rst,
   input  logic         job_valid,
   output logic         job_ready,
   input  logic [255:0] job_target,
   input  logic [607:0] job_msg,
   output logic         res_valid,
   input  logic         res_ready,
   output logic         res_found,
   output logic [31:0]  res_nonce,
   input  logic         abort,
   output logic [4:0]   master_addr,
   output logic [31:0]  master_writedata,
   output logic         master_write,
   output logic         master_read,
   output logic         master_chipselect,
   input  logic [31:0]  master_readdata
);

   localparam int               GAP_W    = (POLL_GAP < 2) ? 1 : $clog2(POLL_GAP);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);

   state_e            state_q, state_d;
   logic [4:0]        wcnt_q, wcnt_d;
   logic              rd_phase_q, rd_phase_d;     // 0: read strobe, 1: data cycle
   logic              abort_path_q, abort_path_d; // CTRL_CLR entered by abort
   logic [7:0][31:0]  tgt_q, tgt_d;
   logic [18:0][31:0] msg_q, msg_d;
   logic              res_found_q, res_found_d;
   logic [31:0]       res_nonce_q, res_nonce_d;
   logic              job_ready_q, job_ready_d;
   logic              res_valid_q, res_valid_d;
   bus_t              bus_q, bus_d;

   logic              abort_hit_s;
   logic              gap_clr_s;
   logic              gap_en_s;
   logic [GAP_W-1:0]  gap_cnt_s;
   logic [4:0]        msg_idx_s;

   // Poll-gap timer: restarts on every entry into POLL_WAIT
   assign gap_clr_s = (state_d == POLL_WAIT) && (state_q != POLL_WAIT);
   assign gap_en_s  = (state_q == POLL_WAIT);

   miner_host_master_counter #(
      .WIDTH (GAP_W)
   ) u_gap_cnt (
      .clk   (clk),
      .n_rst (n_rst),
      .clr   (gap_clr_s),
      .en    (gap_en_s),
      .count (gap_cnt_s)
   );

   // Abort applies outside IDLE, is not re-taken while the abort write is
   // on the bus, and yields to a completing result handshake.
   assign abort_hit_s = abort
                        && (state_q != IDLE)
                        && !abort_path_q
                        && !((state_q == RESULT) && res_ready);

   // Next-state, job capture and result latching
   always_comb begin
      state_d      = state_q;
      wcnt_d       = wcnt_q;
      rd_phase_d   = rd_phase_q;
      abort_path_d = abort_path_q;
      tgt_d        = tgt_q;
      msg_d        = msg_q;
      res_found_d  = res_found_q;
      res_nonce_d  = res_nonce_q;
      if (abort_hit_s) begin
         state_d      = CTRL_CLR;
         wcnt_d       = 5'd0;
         rd_phase_d   = 1'b0;
         abort_path_d = 1'b1;
         res_found_d  = 1'b0;
         res_nonce_d  = 32'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (job_valid && job_ready_q) begin
                  tgt_d   = job_target;
                  msg_d   = job_msg;
                  wcnt_d  = 5'd0;
                  state_d = WR_TGT;
               end else begin
                  state_d = IDLE;
               end
            end
            WR_TGT: begin
               if (wcnt_q >= TGT_LAST) begin
                  wcnt_d  = 5'd0;
                  state_d = WR_MSG;
               end else begin
                  wcnt_d  = wcnt_q + 5'd1;
               end
            end
            WR_MSG: begin
               if (wcnt_q >= MSG_LAST) begin
                  wcnt_d       = 5'd0;
                  abort_path_d = 1'b0;
                  state_d      = CTRL_CLR;
               end else begin
                  wcnt_d       = wcnt_q + 5'd1;
               end
            end
            CTRL_CLR: begin
               if (abort_path_q) begin
                  abort_path_d = 1'b0;
                  state_d      = IDLE;
               end else begin
                  state_d      = CTRL_SET;
               end
            end
            CTRL_SET: begin
               state_d = POLL_WAIT;
            end
            POLL_WAIT: begin
               if (gap_cnt_s >= GAP_LAST) begin
                  rd_phase_d = 1'b0;
                  state_d    = POLL_RD;
               end else begin
                  state_d    = POLL_WAIT;
               end
            end
            POLL_RD: begin
               if (!rd_phase_q) begin
                  rd_phase_d = 1'b1;
               end else begin
                  rd_phase_d = 1'b0;
                  if (!master_readdata[0]) begin
                     state_d     = POLL_WAIT;
                  end else if (master_readdata[1]) begin
                     res_found_d = 1'b1;
                     state_d     = NONCE_RD;
                  end else begin
                     res_found_d = 1'b0;
                     res_nonce_d = 32'd0;
                     state_d     = RESULT;
                  end
               end
            end
            NONCE_RD: begin
               if (!rd_phase_q) begin
                  rd_phase_d  = 1'b1;
               end else begin
                  rd_phase_d  = 1'b0;
                  res_nonce_d = master_readdata;
                  state_d     = RESULT;
               end
            end
            RESULT: begin
               if (res_ready) begin
                  res_found_d = 1'b0;
                  res_nonce_d = 32'd0;
                  state_d     = IDLE;
               end else begin
                  state_d     = RESULT;
               end
            end
            default: begin
               wcnt_d       = 5'd0;
               rd_phase_d   = 1'b0;
               abort_path_d = 1'b0;
               state_d      = IDLE;
            end
         endcase
      end
   end

   assign job_ready_d = (state_d == IDLE);
   assign res_valid_d = (state_d == RESULT);
   assign msg_idx_s   = (wcnt_d <= MSG_LAST) ? wcnt_d : 5'd0;

   // Bus access for the next state; counters outside their range never drive the bus
   always_comb begin
      bus_d = '0;
      case (state_d)
         WR_TGT: begin
            if (wcnt_d <= TGT_LAST) begin
               bus_d = bus_write(TGT_BASE + wcnt_d, tgt_d[wcnt_d[2:0]]);
            end else begin
               bus_d = '0;
            end
         end
         WR_MSG: begin
            if (wcnt_d <= MSG_LAST) begin
               bus_d = bus_write(MSG_BASE + wcnt_d, msg_d[msg_idx_s]);
            end else begin
               bus_d = '0;
            end
         end
         CTRL_CLR: bus_d = bus_write(CTRL_ADDR, CTRL_CLR_VAL);
         CTRL_SET: bus_d = bus_write(CTRL_ADDR, CTRL_SET_VAL);
         POLL_RD: begin
            if (!rd_phase_d) begin
               bus_d = bus_read(STATUS_ADDR);
            end else begin
               bus_d = '0;
            end
         end
         NONCE_RD: begin
            if (!rd_phase_d) begin
               bus_d = bus_read(NONCE_ADDR);
            end else begin
               bus_d = '0;
            end
         end
         default: bus_d = '0;
      endcase
   end

   // FSM state, captured job and all registered outputs
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q      <= IDLE;
         wcnt_q       <= 5'd0;
         rd_phase_q   <= 1'b0;
         abort_path_q <= 1'b0;
         tgt_q        <= '0;
         msg_q        <= '0;
         res_found_q  <= 1'b0;
         res_nonce_q  <= 32'd0;
         job_ready_q  <= 1'b1;
         res_valid_q  <= 1'b0;
         bus_q        <= '0;
      end else begin
         state_q      <= state_d;
         wcnt_q       <= wcnt_d;
         rd_phase_q   <= rd_phase_d;
         abort_path_q <= abort_path_d;
         tgt_q        <= tgt_d;
         msg_q        <= msg_d;
         res_found_q  <= res_found_d;
         res_nonce_q  <= res_nonce_d;
         job_ready_q  <= job_ready_d;
         res_valid_q  <= res_valid_d;
         bus_q        <= bus_d;
      end
   end

   assign job_ready         = job_ready_q;
   assign res_valid         = res_valid_q;
   assign res_found         = res_found_q;
   assign res_nonce         = res_nonce_q;
   assign master_addr       = bus_q.addr;
   assign master_writedata  = bus_q.wdata;
   assign master_write      = bus_q.wr;
   assign master_read       = bus_q.rd;
   assign master_chipselect = bus_q.cs;

endmodule

// File: tb/tb_miner_host_master.sv
// Directed self-checking bench for miner_host_master with a latency-1 slave model.
module tb_miner_host_master;

   localparam int         POLL_GAP    = 4;
   localparam logic [4:0] STATUS_ADDR = 5'd0;
   localparam logic [4:0] NONCE_ADDR  = 5'd10;

   logic         clk = 1'b0;
   logic         n_rst;
   logic         job_valid;
   logic         job_ready;
   logic [255:0] job_target;
   logic [607:0] job_msg;
   logic         res_valid;
   logic         res_ready;
   logic         res_found;
   logic [31:0]  res_nonce;
   logic         abort;
   logic [4:0]   master_addr;
   logic [31:0]  master_writedata;
   logic         master_write;
   logic         master_read;
   logic         master_chipselect;
   logic [31:0]  master_readdata;

   always #5 clk = ~clk;

   miner_host_master #(
      .POLL_GAP    (POLL_GAP),
      .STATUS_ADDR (STATUS_ADDR),
      .NONCE_ADDR  (NONCE_ADDR)
   ) dut (
      .clk               (clk),
      .n_rst             (n_rst),
      .job_valid         (job_valid),
      .job_ready         (job_ready),
      .job_target        (job_target),
      .job_msg           (job_msg),
      .res_valid         (res_valid),
      .res_ready         (res_ready),
      .res_found         (res_found),
      .res_nonce         (res_nonce),
      .abort             (abort),
      .master_addr       (master_addr),
      .master_writedata  (master_writedata),
      .master_write      (master_write),
      .master_read       (master_read),
      .master_chipselect (master_chipselect),
      .master_readdata   (master_readdata)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- slave model and bus monitor ----------------
   int          cyc = 0;
   int          acc_cyc = 0;
   int          acc_cnt = 0;
   int          poll_cnt = 0;
   int          poll_base = 0;
   int          nonce_cnt = 0;
   int          rv_cnt = 0;
   int          bus_err = 0;
   int          status_mode = 0;
   bit          mon_en = 1'b0;
   int          rd_cyc_q[$];
   logic [4:0]  wa_q[$];
   logic [31:0] wd_q[$];

   // mode 1: complete+found on 3rd poll; mode 2: complete, not found on 1st; else busy
   function automatic logic [31:0] status_word(input int n);
      if (status_mode == 1) return (n >= 3) ? 32'd3 : 32'd0;
      else if (status_mode == 2) return 32'd1;
      else return 32'd0;
   endfunction

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mon_en) begin
         if (job_valid && job_ready) begin
            acc_cyc <= cyc;
            acc_cnt <= acc_cnt + 1;
         end
         if (res_valid) rv_cnt <= rv_cnt + 1;
         if ((master_chipselect !== (master_write | master_read)) || (master_write && master_read))
            bus_err <= bus_err + 1;
         if (!master_chipselect && ((master_addr != 5'd0) || (master_writedata != 32'd0)))
            bus_err <= bus_err + 1;
         if (master_write && master_chipselect) begin
            wa_q.push_back(master_addr);
            wd_q.push_back(master_writedata);
         end
      end
      if (master_read === 1'b1 && master_chipselect === 1'b1) begin
         if (master_addr == STATUS_ADDR) begin
            rd_cyc_q.push_back(cyc - 1);
            master_readdata <= status_word(poll_cnt - poll_base + 1);
            poll_cnt        <= poll_cnt + 1;
         end else if (master_addr == NONCE_ADDR) begin
            master_readdata <= 32'h0000_BEEF;
            nonce_cnt       <= nonce_cnt + 1;
         end else begin
            master_readdata <= 32'hDEAD_BEE0;
         end
      end else begin
         master_readdata <= 32'hA5A5_A5A4;
      end
   end

   task automatic wait_res(input int budget);
      for (int k = 0; k < budget && res_valid !== 1'b1; k++) @(negedge clk);
      chk("res_valid_arrives", {63'd0, res_valid}, 64'd1);
   endtask

   task automatic send_job();
      job_valid = 1'b1;
      @(negedge clk);
      job_valid = 1'b0;
      chk("job_ready_busy", {63'd0, job_ready}, 64'd0);
   endtask

   int wstart, rstart, nstart, rv0, wsz, acc0;
   bit hit;

   initial begin
      n_rst = 1'b0; job_valid = 1'b0; res_ready = 1'b0; abort = 1'b0;
      job_target = '0; job_msg = '0;
      repeat (3) @(negedge clk);
      chk("rst_job_ready", {63'd0, job_ready}, 64'd1);
      chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
      chk("rst_res_found", {63'd0, res_found}, 64'd0);
      chk("rst_res_nonce", {32'd0, res_nonce}, 64'd0);
      chk("rst_bus", {25'd0, master_chipselect, master_write, master_read, master_addr, master_writedata}, 64'd0);
      n_rst = 1'b1; mon_en = 1'b1;

      // abort in IDLE is ignored
      abort = 1'b1;
      repeat (3) @(negedge clk);
      abort = 1'b0;
      chk("idle_abort_ready", {63'd0, job_ready}, 64'd1);
      chk("idle_abort_writes", 64'(wa_q.size()), 64'd0);

      // job 1: found on 3rd poll
      status_mode = 1; poll_base = poll_cnt;
      wstart = wa_q.size(); rstart = rd_cyc_q.size(); nstart = nonce_cnt;
      job_target = 256'h1;
      for (int j = 0; j < 19; j++) job_msg[32*j +: 32] = 32'(j);
      send_job();
      wait_res(200);
      chk("j1_write_count", 64'(wa_q.size() - wstart), 64'd29);
      for (int i = 0; i < 29; i++) begin
         logic [4:0]  ea;
         logic [31:0] ed;
         if (i < 8) begin ea = 5'(2 + i); ed = (i == 0) ? 32'd1 : 32'd0; end
         else if (i < 27) begin ea = 5'(11 + i - 8); ed = 32'(i - 8); end
         else begin ea = 5'd1; ed = (i == 27) ? 32'd0 : 32'd3; end
         chk($sformatf("j1_wr%0d_addr", i), {59'd0, wa_q[wstart + i]}, {59'd0, ea});
         chk($sformatf("j1_wr%0d_data", i), {32'd0, wd_q[wstart + i]}, {32'd0, ed});
      end
      chk("j1_poll_count", 64'(rd_cyc_q.size() - rstart), 64'd3);
      chk("j1_first_poll", 64'(rd_cyc_q[rstart] - acc_cyc), 64'd33);
      chk("j1_poll_gap2", 64'(rd_cyc_q[rstart + 1] - rd_cyc_q[rstart]), 64'd6);
      chk("j1_poll_gap3", 64'(rd_cyc_q[rstart + 2] - rd_cyc_q[rstart + 1]), 64'd6);
      chk("j1_nonce_reads", 64'(nonce_cnt - nstart), 64'd1);
      chk("j1_res_found", {63'd0, res_found}, 64'd1);
      chk("j1_res_nonce", {32'd0, res_nonce}, 64'h0000_BEEF);
      // abort together with res_ready completes normally
      res_ready = 1'b1; abort = 1'b1;
      wsz = wa_q.size();
      @(negedge clk);
      res_ready = 1'b0; abort = 1'b0;
      chk("j1_done_valid", {63'd0, res_valid}, 64'd0);
      chk("j1_done_ready", {63'd0, job_ready}, 64'd1);
      repeat (3) @(negedge clk);
      chk("j1_no_abort_write", 64'(wa_q.size()), 64'(wsz));

      // job 2: complete without find on 1st poll
      status_mode = 2; poll_base = poll_cnt;
      rstart = rd_cyc_q.size(); nstart = nonce_cnt;
      job_target = {8{32'hC0DE_0000}};
      send_job();
      wait_res(200);
      chk("j2_poll_count", 64'(rd_cyc_q.size() - rstart), 64'd1);
      chk("j2_nonce_reads", 64'(nonce_cnt - nstart), 64'd0);
      chk("j2_res_found", {63'd0, res_found}, 64'd0);
      chk("j2_res_nonce", {32'd0, res_nonce}, 64'd0);
      // hold off res_ready for 10 cycles while a new job is offered
      status_mode = 0;
      job_target = 256'h2;
      for (int j = 0; j < 19; j++) job_msg[32*j +: 32] = 32'h1000_0000 + 32'(j);
      job_valid = 1'b1;
      wsz = wa_q.size();
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk($sformatf("hold%0d_valid", k), {63'd0, res_valid}, 64'd1);
         chk($sformatf("hold%0d_found", k), {63'd0, res_found}, 64'd0);
         chk($sformatf("hold%0d_nonce", k), {32'd0, res_nonce}, 64'd0);
         chk($sformatf("hold%0d_ready", k), {63'd0, job_ready}, 64'd0);
      end
      chk("hold_no_writes", 64'(wa_q.size()), 64'(wsz));
      acc0 = acc_cnt;
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk("hold_release_ready", {63'd0, job_ready}, 64'd1);
      rv0 = rv_cnt;
      wstart = wa_q.size();
      @(negedge clk);
      job_valid = 1'b0;
      chk("hold_accepted", 64'(acc_cnt - acc0), 64'd1);
      chk("j3_busy", {63'd0, job_ready}, 64'd0);

      // job 3: abort during message word 5
      hit = 1'b0;
      for (int k = 0; k < 40 && !hit; k++) begin
         if (master_write === 1'b1 && master_addr == 5'd16) hit = 1'b1;
         else @(negedge clk);
      end
      chk("j3_reach_word5", {63'd0, hit}, 64'd1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_wr", {63'd0, master_write}, 64'd1);
      chk("abort_addr", {59'd0, master_addr}, 64'd1);
      chk("abort_data", {32'd0, master_writedata}, 64'd0);
      @(negedge clk);
      chk("abort_ready", {63'd0, job_ready}, 64'd1);
      chk("abort_bus_idle", {62'd0, master_write, master_chipselect}, 64'd0);
      chk("abort_write_count", 64'(wa_q.size() - wstart), 64'd15);
      chk("abort_w5_addr", {59'd0, wa_q[wstart + 13]}, 64'd16);
      chk("abort_w5_data", {32'd0, wd_q[wstart + 13]}, 64'h1000_0005);
      chk("abort_last_addr", {59'd0, wa_q[wstart + 14]}, 64'd1);
      chk("abort_last_data", {32'd0, wd_q[wstart + 14]}, 64'd0);
      wsz = wa_q.size();
      repeat (5) @(negedge clk);
      chk("abort_quiet", 64'(wa_q.size()), 64'(wsz));
      chk("abort_no_res_valid", 64'(rv_cnt), 64'(rv0));

      // job 4: reset while in POLL_WAIT
      rstart = rd_cyc_q.size();
      send_job();
      hit = 1'b0;
      for (int k = 0; k < 100 && !hit; k++) begin
         if (rd_cyc_q.size() > rstart) hit = 1'b1;
         else @(negedge clk);
      end
      chk("j4_first_poll_seen", {63'd0, hit}, 64'd1);
      @(negedge clk);
      n_rst = 1'b0;
      wsz = wa_q.size();
      @(negedge clk);
      chk("mid_rst_job_ready", {63'd0, job_ready}, 64'd1);
      chk("mid_rst_res", {62'd0, res_valid, res_found}, 64'd0);
      chk("mid_rst_nonce", {32'd0, res_nonce}, 64'd0);
      chk("mid_rst_bus", {25'd0, master_chipselect, master_write, master_read, master_addr, master_writedata}, 64'd0);
      repeat (3) @(negedge clk);
      n_rst = 1'b1;
      repeat (5) @(negedge clk);
      chk("mid_rst_no_ctrl_write", 64'(wa_q.size()), 64'(wsz));
      chk("mid_rst_idle", {63'd0, job_ready}, 64'd1);
      chk("bus_protocol", 64'(bus_err), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
